// File: rtl/conv_host_pkg.sv
// Shared types and sizing helpers for the convolution stream host.
package conv_host_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  function automatic int unsigned y_len(input int unsigned size_x, input int unsigned size_f);
    return size_x - size_f + 1;
  endfunction

  // Width of a counter that must be able to hold the value n itself.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  function automatic int unsigned addr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_host_xfetch.sv
// Sample fetcher: walks the X buffer, absorbs the read latency and keeps a 2-entry skid
// so beats leave on back-to-back cycles while honouring x_ready.
module conv_host_xfetch import conv_host_pkg::*; #(
  parameter int unsigned T      = 16,
  parameter int unsigned SIZE_X = 112,
  localparam int unsigned LOGX  = $clog2(SIZE_X),
  localparam int unsigned CW    = cnt_w(SIZE_X)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                run,
  output logic [LOGX-1:0]     fetch_addr,
  input  logic [T-1:0]        mem_rdata,
  output logic signed [T-1:0] x_data,
  output logic                x_valid,
  input  logic                x_ready
);

  logic [CW-1:0] ptr_q, ptr_d;
  logic          inflight_q, inflight_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [T-1:0]  skid_q [2];
  logic [T-1:0]  skid_d [2];
  logic          pop, pop_skid, push, issue;
  logic [1:0]    occ;

  assign fetch_addr = ptr_q[LOGX-1:0];

  always_comb begin
    x_valid    = (cnt_q != 2'd0) || inflight_q;
    x_data     = '0;
    // Skid head has priority; an empty skid passes the memory word straight through.
    if (cnt_q != 2'd0) begin
      x_data = skid_q[0];
    end else if (inflight_q) begin
      x_data = mem_rdata;
    end
    pop        = x_valid && x_ready;
    pop_skid   = pop && (cnt_q != 2'd0);
    push       = inflight_q && !(pop && (cnt_q == 2'd0));
    // Only issue a read if its data is guaranteed a slot when it lands.
    occ        = cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    issue      = run && (ptr_q != CW'(SIZE_X)) && (occ < 2'd2);

    skid_d     = skid_q;
    cnt_d      = cnt_q;
    if (pop_skid) begin
      skid_d[0] = skid_q[1];
      cnt_d     = cnt_q - 2'd1;
    end
    if (push) begin
      if (cnt_d == 2'd0) begin
        skid_d[0] = mem_rdata;
      end else begin
        skid_d[1] = mem_rdata;
      end
      cnt_d = cnt_d + 2'd1;
    end

    inflight_d = issue;
    ptr_d      = issue ? ptr_q + CW'(1) : ptr_q;
    if (clear) begin
      cnt_d      = '0;
      inflight_d = 1'b0;
      ptr_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q      <= '0;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      ptr_q      <= ptr_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    skid_q <= skid_d;
  end

endmodule

// File: rtl/sp_mem.sv
// Single-port synchronous memory with a registered read port (1-cycle latency).
module sp_mem #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SIZE  = 16,
  localparam int unsigned AW   = $clog2(SIZE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [SIZE];

  // Contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (reset && we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata <= '0;
    end else begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/conv_stream_host.sv
// Host-side initiator for the convolution engine stream port.
// Optional Y_CHECKSUM_EN adds a running modulo-2^T sum of accepted results on y_sum.
module conv_stream_host import conv_host_pkg::*; #(
  parameter int unsigned T       = 16,
  parameter int unsigned SIZE_X  = 112,
  parameter int unsigned SIZE_F  = 49,
  localparam int unsigned SIZE_Y = y_len(SIZE_X, SIZE_F),
  localparam int unsigned LOGX   = $clog2(SIZE_X),
  localparam int unsigned LOGY   = $clog2(SIZE_Y)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ld_we,
  input  logic [LOGX-1:0]     ld_addr,
  input  logic [T-1:0]        ld_data,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic signed [T-1:0] x_data,
  output logic                x_valid,
  input  logic                x_ready,
  input  logic signed [T-1:0] y_data,
  input  logic                y_valid,
  output logic                y_ready,
`ifdef Y_CHECKSUM_EN
  output logic [T-1:0]        y_sum,
`endif
  input  logic [LOGY-1:0]     rd_addr,
  output logic [T-1:0]        rd_data
);

  localparam int unsigned XCW = cnt_w(SIZE_X);
  localparam int unsigned YCW = cnt_w(SIZE_Y);

  state_e          state_q, state_d;
  logic [XCW-1:0]  x_cnt_q;
  logic [YCW-1:0]  y_cnt_q;
  logic            run, go, x_end, y_end, x_fire, y_fire;
  logic [LOGX-1:0] fetch_addr, xmem_addr;
  logic [T-1:0]    xmem_rdata;
  logic [LOGY-1:0] ymem_addr;

  assign run    = (state_q == StRun);
  assign go     = start && !run;
  assign x_end  = (x_cnt_q == XCW'(SIZE_X));
  assign y_end  = (y_cnt_q == YCW'(SIZE_Y));
  assign x_fire = x_valid && x_ready;
  assign y_fire = y_valid && y_ready;

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    y_ready = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StRun;
      end
      StRun: begin
        busy    = 1'b1;
        y_ready = !y_end;
        if (x_end && y_end) state_d = StDone;
      end
      StDone: begin
        done = 1'b1;
        if (start) state_d = StRun;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      x_cnt_q <= '0;
      y_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (go) begin
        x_cnt_q <= '0;
        y_cnt_q <= '0;
      end else begin
        if (x_fire) x_cnt_q <= x_cnt_q + XCW'(1);
        if (y_fire) y_cnt_q <= y_cnt_q + YCW'(1);
      end
    end
  end

`ifdef Y_CHECKSUM_EN
  logic [T-1:0] y_sum_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      y_sum_q <= '0;
    end else if (go) begin
      y_sum_q <= '0;
    end else if (y_fire) begin
      y_sum_q <= y_sum_q + $unsigned(y_data);
    end
  end

  assign y_sum = y_sum_q;
`endif

  // The host owns both buffers outside a run; the datapath owns them during one.
  assign xmem_addr = run ? fetch_addr : ld_addr;
  assign ymem_addr = run ? y_cnt_q[LOGY-1:0] : rd_addr;

  sp_mem #(
    .WIDTH (T),
    .SIZE  (SIZE_X)
  ) u_xmem (
    .clk   (clk),
    .reset (reset),
    .we    (ld_we && !run),
    .addr  (xmem_addr),
    .wdata (ld_data),
    .rdata (xmem_rdata)
  );

  sp_mem #(
    .WIDTH (T),
    .SIZE  (SIZE_Y)
  ) u_ymem (
    .clk   (clk),
    .reset (reset),
    .we    (y_fire),
    .addr  (ymem_addr),
    .wdata ($unsigned(y_data)),
    .rdata (rd_data)
  );

  conv_host_xfetch #(
    .T      (T),
    .SIZE_X (SIZE_X)
  ) u_xfetch (
    .clk        (clk),
    .reset      (reset),
    .clear      (go),
    .run        (run),
    .fetch_addr (fetch_addr),
    .mem_rdata  (xmem_rdata),
    .x_data     (x_data),
    .x_valid    (x_valid),
    .x_ready    (x_ready)
  );

endmodule

// File: doc/conv_stream_host.md
Name: conv_stream_host

Overview:
Host-side initiator for the convolution engine's stream interface: it drives x_data/x_valid into the engine and sinks y_data/y_valid with y_ready.
- A host preloads SIZE_X input samples through a write port, then pulses start.
- The block streams the samples out at full throughput, honouring x_ready.
- It captures SIZE_Y = SIZE_X-SIZE_F+1 results into a result buffer the host reads back after done.

Parameters:
T, 16, sample/result width in bits
SIZE_X, 112, number of input samples per run
SIZE_F, 49, filter length; only used to derive SIZE_Y
(derived localparams) SIZE_Y = SIZE_X-SIZE_F+1; LOGX = $clog2(SIZE_X); LOGY = $clog2(SIZE_Y)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low (0 = reset)
ld_we  in  1  host write enable for the X buffer
ld_addr  in  LOGX  host write address
ld_data  in  T  host write data
start  in  1  begin a run (single-cycle pulse)
busy  out  1  high while running
done  out  1  high from run completion until the next start
x_data  out  T signed  sample to engine
x_valid  out  1  x_data valid
x_ready  in  1  engine accepts x
y_data  in  T signed  result from engine
y_valid  in  1  y_data valid
y_ready  out  1  block accepts y
rd_addr  in  LOGY  host read address into the result buffer
rd_data  out  T  result buffer data, 1-cycle latency

Behaviour:
- FSM states: IDLE, RUN, DONE.
- Reset (reset==0) forces:
  - state IDLE; busy, done, x_valid and y_ready all 0; x_data 0; rd_data 0.
  - x_cnt, y_cnt and fetch pointers 0.
  - Buffer contents are not cleared.
- IDLE/DONE:
  - ld_we writes ld_data to X[ld_addr].
  - rd_addr drives the Y buffer address; rd_data = Y[rd_addr] one cycle later.
- IDLE/DONE + start -> RUN: busy=1, done=0, counters cleared.
- start while in RUN is ignored. ld_we while in RUN is ignored (no write).
- RUN, X side:
  - X[0..SIZE_X-1] are presented in order.
  - First x_valid is asserted no later than 2 cycles after start (1-cycle memory read latency).
  - A beat transfers when x_valid && x_ready.
  - x_data/x_valid stay stable while x_ready==0.
  - With x_ready held at 1, beats go out on consecutive cycles with no bubbles. This needs a 2-entry prefetch/skid buffer.
  - After SIZE_X beats: x_valid=0 and stays 0.
- RUN, Y side:
  - y_ready=1 while y_cnt<SIZE_Y, otherwise 0.
  - On y_valid && y_ready, Y[y_cnt] <= y_data and y_cnt increments.
  - y_valid beyond SIZE_Y results is never accepted.
- The X and Y sides run concurrently. Y may arrive before the last X beat; nothing stalls either side.
- RUN -> DONE in the cycle after both x_cnt==SIZE_X and y_cnt==SIZE_Y: busy=0, done=1. done is held until the next start.
- Buffer address muxes:
  - X buffer: RUN uses the fetch pointer, otherwise ld_addr.
  - Y buffer: RUN uses y_cnt, otherwise rd_addr.
  - rd_data during RUN is don't-care.
- Reset mid-run: immediate return to IDLE per the reset values above; any partial results remain in the Y buffer.
- No arithmetic on data; y_data is stored verbatim as T bits.

Optional Feature:
Y_CHECKSUM_EN.
- Defined:
  - Adds output port y_sum [T-1:0], reset to 0 and cleared on start.
  - Each accepted y beat adds y_data, wrapping modulo 2^T.
  - Value is stable in DONE.
- Undefined: the port and adder are absent; all other behaviour is identical.

Decomposition:
- Package conv_host_pkg holds:
  - state enum typedef (IDLE, RUN, DONE)
  - function y_len(SIZE_X, SIZE_F) returning SIZE_X-SIZE_F+1
  - clog2-based width helpers
- Both buffers reuse the existing single-port memory module (WIDTH=T, SIZE=SIZE_X or SIZE_Y).
- One sub-module: conv_host_xfetch. It owns the fetch pointer, the read-latency pipeline and the 2-entry skid, and produces x_data/x_valid from the memory read data.

Test Plan:
- Test configuration: SIZE_X=8, SIZE_F=3, T=16; X loaded 1..8; start; x_ready and y_ready tied high; engine model returns y[i]=x[i]+x[i+1]+x[i+2]. Required response:
  - x beats 1..8 on 8 consecutive cycles.
  - Y buffer reads 6,9,12,15,18,21.
  - done=1, and y_sum=81 if Y_CHECKSUM_EN.
- x_ready toggles 1,0,0,1,...: x_data is held stable during the stall cycles; no sample is duplicated or dropped; 8 beats total.
- Engine model offers a 7th y_valid: y_ready=0 after 6 accepts; Y buffer is unchanged; done asserts.
- start pulsed during RUN, and ld_we to address 0 with value 0xFFFF during RUN: both ignored; outputs match the first scenario.
- reset=0 at the 4th x beat: next cycle busy=0, x_valid=0, y_ready=0. After reset=1 and start, a full run completes correctly.
- Back-to-back runs: start asserted in DONE with new X data (e.g. X=10..17): done drops; the second run's Y results overwrite the first run's in the Y buffer.
